// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with a one-clock start handshake
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    STOP_IDX = 4'd9;

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          bit_end;

    // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit
    assign bit_end = tx_busy && (clk_cnt == LAST_CLK);
    assign tx_done = bit_end && (bit_idx == STOP_IDX);

    // Frame sequencer: shreg holds the remaining data bits with the stop bit on top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_line <= 1'b1;
            tx_busy <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx_line <= 1'b0;
                clk_cnt <= '0;
                bit_idx <= '0;
                shreg   <= {1'b1, tx_byte};
            end
        end else if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx_line <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_reader.sv
// rtl/rom_reader.sv - dumps instruction memory words over UART, little-endian bytes
module rom_reader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] im_ra,
    input  logic [31:0] im_rd,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [10:0] LAST_WORD = 11'(DEPTH - 1);

    state_t      state;
    state_t      next_state;
    logic [10:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] buffer;
    logic [10:0] ra;
    logic        issued;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;

    assign im_ra = {21'd0, ra};
    assign busy  = (state != S_IDLE) && (state != S_DONE);
    assign done  = (state == S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and transmitter kick; one tx_start per byte, tracked by issued
    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        case (state)
            S_IDLE: if (start) next_state = S_ADDR;
            S_ADDR: next_state = S_WAIT;
            S_WAIT: next_state = S_LOAD;
            S_LOAD: next_state = S_SEND;
            S_SEND: begin
                tx_start = !issued && !tx_busy;
                if (issued && tx_done && (byte_cnt == 2'd3)) next_state = S_NEXT;
            end
            S_NEXT: next_state = (word_cnt == LAST_WORD) ? S_DONE : S_ADDR;
            S_DONE: if (!start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Word/byte counters, read address and the byte shift buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            buffer   <= '0;
            ra       <= '0;
            issued   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) word_cnt <= '0;
                S_ADDR: ra <= word_cnt;
                S_LOAD: begin
                    buffer   <= im_rd;
                    byte_cnt <= '0;
                    issued   <= 1'b0;
                end
                S_SEND: begin
                    if (tx_start) begin
                        issued <= 1'b1;
                    end else if (issued && tx_done) begin
                        issued   <= 1'b0;
                        buffer   <= {8'h00, buffer[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_NEXT: if (word_cnt != LAST_WORD) word_cnt <= word_cnt + 11'd1;
                default: ;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_byte (buffer[7:0]),
        .tx_line (uart_tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

endmodule
